// File: rtl/countdown_timer_pkg.sv
// Shared types and encodings for the countdown timer and its prescaler.
package countdown_timer_pkg;

  // Width of the FSM state register
  localparam int unsigned STATE_W = 2;

  // State encodings, kept as named constants so checkers and debug views agree
  localparam logic [STATE_W-1:0] ENC_IDLE = 2'b00;
  localparam logic [STATE_W-1:0] ENC_RUN  = 2'b01;
  localparam logic [STATE_W-1:0] ENC_DONE = 2'b10;

  // Timer FSM states
  typedef enum logic [STATE_W-1:0] {
    IDLE = ENC_IDLE,
    RUN  = ENC_RUN,
    DONE = ENC_DONE
  } state_e;

  // True in the states where a new start value may be taken
  function automatic logic state_accepts_load(input state_e s);
    logic ok;
    case (s)
      IDLE:    ok = 1'b1;
      DONE:    ok = 1'b1;
      RUN:     ok = 1'b0;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Divides enabled cycles by P+1: tick is high on the enabled cycle in which
// the internal phase counter has reached P, after which the phase restarts.
module tick_prescaler
  import countdown_timer_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] p,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pre_r;
  logic                  at_limit_s;

  // Phase has reached the programmed divider (equality only, so P = all-ones is legal)
  always_comb begin
    at_limit_s = 1'b0;
    if (pre_r == p) begin
      at_limit_s = 1'b1;
    end else begin
      at_limit_s = 1'b0;
    end
  end

  // Tick only when counting is enabled this cycle
  always_comb begin
    tick = 1'b0;
    if (enable && at_limit_s) begin
      tick = 1'b1;
    end else begin
      tick = 1'b0;
    end
  end

  // Phase counter: clear wins over enable; hold while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_r <= {PRESCALE_W{1'b0}};
    end else if (clear) begin
      pre_r <= {PRESCALE_W{1'b0}};
    end else if (enable) begin
      if (at_limit_s) begin
        pre_r <= {PRESCALE_W{1'b0}};
      end else begin
        pre_r <= pre_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
      end
    end else begin
      pre_r <= pre_r;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaler. A start value is taken over a
// valid/ready handshake, counted down to zero at one step per P+1 enabled
// cycles, and a one-cycle ping marks terminal count. Optional auto-reload
// restarts the same value after each ping for periodic events.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [WIDTH-1:0]      load_value,
  input  logic [PRESCALE_W-1:0] load_prescale,
  input  logic                  load_reload,
  input  logic                  pause,
  input  logic                  abort,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  ping
);

  state_e                state_r;
  logic [WIDTH-1:0]      count_r;
  logic [WIDTH-1:0]      n_r;
  logic [PRESCALE_W-1:0] p_r;
  logic                  reload_r;
  logic                  busy_r;
  logic                  ping_r;

  logic                  accept_s;
  logic                  reload_go_s;
  logic                  pre_clear_s;
  logic                  pre_enable_s;
  logic                  tick_s;
  logic                  count_zero_s;

  // Ready in IDLE/DONE unless aborting or held in reset
  always_comb begin
    load_ready = 1'b0;
    if (rst) begin
      load_ready = 1'b0;
    end else if (abort) begin
      load_ready = 1'b0;
    end else begin
      load_ready = state_accepts_load(state_r);
    end
  end

  // Handshake, reload and prescaler control decode
  always_comb begin
    accept_s     = load_valid & load_ready;
    reload_go_s  = 1'b0;
    pre_enable_s = 1'b0;
    if ((state_r == DONE) && reload_r) begin
      reload_go_s = 1'b1;
    end else begin
      reload_go_s = 1'b0;
    end
    if ((state_r == RUN) && !pause) begin
      pre_enable_s = 1'b1;
    end else begin
      pre_enable_s = 1'b0;
    end
    pre_clear_s = accept_s | reload_go_s | abort;
  end

  // Terminal-count detection on the current remaining count
  always_comb begin
    count_zero_s = 1'b0;
    if (count_r == {WIDTH{1'b0}}) begin
      count_zero_s = 1'b1;
    end else begin
      count_zero_s = 1'b0;
    end
  end

  tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (pre_clear_s),
    .enable (pre_enable_s),
    .p      (p_r),
    .tick   (tick_s)
  );

  // Timer FSM with registered busy/ping; abort beats everything but reset,
  // and an accepted load in DONE beats auto-reload
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      count_r  <= {WIDTH{1'b0}};
      n_r      <= {WIDTH{1'b0}};
      p_r      <= {PRESCALE_W{1'b0}};
      reload_r <= 1'b0;
      busy_r   <= 1'b0;
      ping_r   <= 1'b0;
    end else if (abort) begin
      state_r  <= IDLE;
      count_r  <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      ping_r   <= 1'b0;
    end else if (accept_s) begin
      state_r  <= RUN;
      count_r  <= load_value;
      n_r      <= load_value;
      p_r      <= load_prescale;
      reload_r <= load_reload;
      busy_r   <= 1'b1;
      ping_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          ping_r  <= 1'b0;
        end
        RUN: begin
          busy_r <= 1'b1;
          if (tick_s) begin
            if (count_zero_s) begin
              state_r <= DONE;
              ping_r  <= 1'b1;
            end else begin
              count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
              ping_r  <= 1'b0;
            end
          end else begin
            ping_r <= 1'b0;
          end
        end
        DONE: begin
          ping_r <= 1'b0;
          if (reload_r) begin
            state_r <= RUN;
            count_r <= n_r;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            count_r <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          count_r <= {WIDTH{1'b0}};
          busy_r  <= 1'b0;
          ping_r  <= 1'b0;
        end
      endcase
    end
  end

  assign count = count_r;
  assign busy  = busy_r;
  assign ping  = ping_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a 32-bit instance for most vectors and
// a 4-bit instance for the full-range no-wrap case.
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_value;
  logic [7:0]  load_prescale;
  logic        load_reload;
  logic        pause;
  logic        abort;
  logic [31:0] count;
  logic        busy;
  logic        ping;

  logic        load_valid4;
  logic        load_ready4;
  logic [3:0]  load_value4;
  logic [7:0]  load_prescale4;
  logic        load_reload4;
  logic        pause4;
  logic        abort4;
  logic [3:0]  count4;
  logic        busy4;
  logic        ping4;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int k     = 0;
  int at    = 0;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(32), .PRESCALE_W(8)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .load_prescale(load_prescale), .load_reload(load_reload),
    .pause(pause), .abort(abort), .count(count), .busy(busy), .ping(ping)
  );

  countdown_timer #(.WIDTH(4), .PRESCALE_W(8)) dut4 (
    .clk(clk), .rst(rst), .load_valid(load_valid4), .load_ready(load_ready4),
    .load_value(load_value4), .load_prescale(load_prescale4), .load_reload(load_reload4),
    .pause(pause4), .abort(abort4), .count(count4), .busy(busy4), .ping(ping4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Present a load for one edge on the 32-bit instance; k = accept edge
  task automatic do_load(input logic [31:0] v, input logic [7:0] p, input logic r);
    load_value    = v;
    load_prescale = p;
    load_reload   = r;
    load_valid    = 1'b1;
    #1;
    chk("ld_ready", {63'd0, load_ready}, 64'd1);
    step();
    load_valid = 1'b0;
    k = cyc;
  endtask

  // Step until ping (bounded); out = edge index of the ping, -1 on timeout
  task automatic wait_ping(input bit sel4, input int budget, output int out);
    out = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if ((sel4 ? ping4 : ping) === 1'b1) begin
        out = cyc;
        break;
      end
    end
  endtask

  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, {63'd0, ping}, 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_value = 32'd0; load_prescale = 8'd0;
    load_reload = 1'b0; pause = 1'b0; abort = 1'b0;
    load_valid4 = 1'b0; load_value4 = 4'd0; load_prescale4 = 8'd0;
    load_reload4 = 1'b0; pause4 = 1'b0; abort4 = 1'b0;
    step(); step();
    chk("rst_count", {32'd0, count}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ping", {63'd0, ping}, 64'd0);
    chk("rst_ready", {63'd0, load_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", {63'd0, load_ready}, 64'd1);

    // 1: N=3 P=0 no reload
    do_load(32'd3, 8'd0, 1'b0);
    chk("t1_c3", {32'd0, count}, 64'd3);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    step(); chk("t1_c2", {32'd0, count}, 64'd2);
    step(); chk("t1_c1", {32'd0, count}, 64'd1);
    step(); chk("t1_c0", {32'd0, count}, 64'd0);
    chk("t1_noping", {63'd0, ping}, 64'd0);
    step(); chk("t1_ping", {63'd0, ping}, 64'd1);
    step();
    chk("t1_ping_off", {63'd0, ping}, 64'd0);
    chk("t1_idle_busy", {63'd0, busy}, 64'd0);
    chk("t1_idle_ready", {63'd0, load_ready}, 64'd1);
    chk("t1_idle_count", {32'd0, count}, 64'd0);

    // 2: N=2 P=3, step every 4 edges, ping after k+12
    do_load(32'd2, 8'd3, 1'b0);
    for (int i = 0; i < 3; i++) step();
    chk("t2_c2_k3", {32'd0, count}, 64'd2);
    step(); chk("t2_c1_k4", {32'd0, count}, 64'd1);
    for (int i = 0; i < 3; i++) step();
    chk("t2_c1_k7", {32'd0, count}, 64'd1);
    step(); chk("t2_c0_k8", {32'd0, count}, 64'd0);
    wait_ping(1'b0, 40, at);
    chk("t2_lat", 64'(at - k), 64'd12);
    step();
    // N=0 P=0
    do_load(32'd0, 8'd0, 1'b0);
    wait_ping(1'b0, 10, at);
    chk("t2_n0_lat", 64'(at - k), 64'd1);
    step();

    // 3: auto-reload N=1 P=0, period 3
    do_load(32'd1, 8'd0, 1'b1);
    wait_ping(1'b0, 10, at); chk("t3_p1", 64'(at - k), 64'd2);
    wait_ping(1'b0, 10, at); chk("t3_p2", 64'(at - k), 64'd5);
    wait_ping(1'b0, 10, at); chk("t3_p3", 64'(at - k), 64'd8);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t3_abort_busy", {63'd0, busy}, 64'd0);
    chk("t3_abort_count", {32'd0, count}, 64'd0);
    quiet("t3_quiet", 6);
    // load during DONE overrides reload
    do_load(32'd1, 8'd0, 1'b1);
    wait_ping(1'b0, 10, at);
    chk("t3_r_ping", 64'(at - k), 64'd2);
    do_load(32'd4, 8'd0, 1'b0);
    chk("t3_override", {32'd0, count}, 64'd4);
    wait_ping(1'b0, 20, at);
    chk("t3_ov_lat", 64'(at - k), 64'd5);
    step();
    chk("t3_ov_idle", {63'd0, busy}, 64'd0);

    // 4: pause for edges k+3..k+5
    do_load(32'd5, 8'd0, 1'b0);
    step(); step();
    chk("t4_c3", {32'd0, count}, 64'd3);
    pause = 1'b1;
    step(); step(); step();
    chk("t4_frozen", {32'd0, count}, 64'd3);
    pause = 1'b0;
    step(); chk("t4_c2", {32'd0, count}, 64'd2);
    wait_ping(1'b0, 20, at);
    chk("t4_lat", 64'(at - k), 64'd9);
    step();

    // 5: reset mid-run at count 7
    do_load(32'd20, 8'd0, 1'b0);
    for (int i = 0; i < 13; i++) step();
    chk("t5_c7", {32'd0, count}, 64'd7);
    rst = 1'b1;
    step();
    chk("t5_rst_count", {32'd0, count}, 64'd0);
    chk("t5_rst_busy", {63'd0, busy}, 64'd0);
    chk("t5_rst_ready", {63'd0, load_ready}, 64'd0);
    rst = 1'b0;
    quiet("t5_quiet", 4);
    // reset on the terminal tick edge
    do_load(32'd0, 8'd0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_term_ping", {63'd0, ping}, 64'd0);
    chk("t5_term_busy", {63'd0, busy}, 64'd0);
    quiet("t5_term_quiet", 3);
    // abort blocks a simultaneous load in IDLE
    abort = 1'b1; load_valid = 1'b1; load_value = 32'd9;
    #1;
    chk("t5_abort_ready", {63'd0, load_ready}, 64'd0);
    step();
    abort = 1'b0; load_valid = 1'b0;
    chk("t5_abort_busy", {63'd0, busy}, 64'd0);
    chk("t5_abort_count", {32'd0, count}, 64'd0);

    // 6: WIDTH=4, N=15 runs to 0 without wrap
    load_value4 = 4'd15; load_prescale4 = 8'd0; load_reload4 = 1'b0; load_valid4 = 1'b1;
    #1;
    chk("t6_ready", {63'd0, load_ready4}, 64'd1);
    step();
    load_valid4 = 1'b0;
    k = cyc;
    chk("t6_c15", {60'd0, count4}, 64'd15);
    for (int i = 0; i < 15; i++) step();
    chk("t6_c0", {60'd0, count4}, 64'd0);
    chk("t6_noping", {63'd0, ping4}, 64'd0);
    step();
    chk("t6_ping", {63'd0, ping4}, 64'd1);
    chk("t6_nowrap", {60'd0, count4}, 64'd0);
    step();
    chk("t6_ping_off", {63'd0, ping4}, 64'd0);
    chk("t6_idle_count", {60'd0, count4}, 64'd0);
    // P=255, N=0 on the 32-bit instance
    do_load(32'd0, 8'd255, 1'b0);
    wait_ping(1'b0, 300, at);
    chk("t6_p255_lat", 64'(at - k), 64'd256);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
